sign_mag_pipe: RTL and testbench
================================

Name: sign_mag_pipe

Overview:
- Parametrised, pipelined two's-complement to sign-magnitude converter for the floating-point conversion datapath.
- Accepts one signed sample per cycle over a valid/ready handshake.
- Returns sign, magnitude, a saturation flag and a leading-zero count two stages later. The leading-zero count feeds exponent/normalisation logic downstream.
- Supersedes the fixed 12-bit combinational inverter with configurable width, backpressure and normalisation support.

Parameters:
- WIDTH, 12, bit width of input sample and output magnitude (min 4).
- LZW, $clog2(WIDTH+1), width of leading-zero count. Derived localparam; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  WIDTH  two's-complement sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- out_sign  out  1  sign of accepted sample (MSB of in_data).
- out_abs  out  WIDTH  magnitude, unsigned.
- out_sat  out  1  magnitude was saturated (input was most-negative value).
- out_lzc  out  LZW  leading zeros of out_abs counted over WIDTH bits.
- out_valid  out  1  out_* fields valid.
- out_ready  in  1  downstream accepts out_* this cycle.
- sat_count  out  16  saturation event counter (see Optional Feature).

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst). All state updates on the rising edge of clk only.
- Reset:
  - Both stage-valid flags clear.
  - All output registers are 0, so out_valid, out_sign, out_abs, out_sat and out_lzc are 0.
  - sat_count is 0.
  - in_ready is 0 while rst is high.
- Handshake:
  - Transfer occurs when valid && ready are both high in the same cycle.
  - in_valid may rise independently of in_ready.
  - Output fields stay stable while out_valid=1 && out_ready=0.
- Pipeline, stage 1 (S1) on accept:
  - s1_sign = in_data[WIDTH-1].
  - If in_data == {1'b1,{WIDTH-1{1'b0}}}: s1_abs = {1'b0,{WIDTH-1{1'b1}}} and s1_sat = 1.
  - Else if the sign bit is set: s1_abs = ~in_data + 1.
  - Else: s1_abs = in_data.
  - Arithmetic is exactly WIDTH bits; no carry out is kept.
- Pipeline, stage 2 (S2): registers s1 fields plus lzc(s1_abs).
  - lzc is the count of zero bits from the MSB down to the first one.
  - lzc = WIDTH when abs == 0.
  - For any nonzero saturated-or-not magnitude, lzc >= 1.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !rst && (!s1_valid || s2_load).
- Latency and throughput:
  - Accepted input appears on out_* exactly 2 cycles later when out_ready is held high.
  - Full throughput of 1 sample/cycle with no bubbles.
- Stall: with out_ready low, up to 2 samples are held (S1, S2). in_ready deasserts in the cycle after S1 fills behind a full S2.
- Ordering: strictly FIFO; no sample is dropped or duplicated.
- Simultaneous events: accept into S1 and S1→S2 move in the same cycle is legal. S1 is overwritten with the new sample after its old contents move.
- Reset mid-operation: in-flight samples are discarded; no partial output is emitted after rst deasserts.
- Zero input: sign 0, abs 0, sat 0, lzc = WIDTH.

Optional Feature:
- Macro: SGNMAG_SAT_CNT_EN.
- Defined:
  - sat_count increments by 1 on every output transfer with out_sat=1.
  - It saturates at 16'hFFFF and does not wrap.
  - Cleared only by rst.
- Undefined: the counter logic is absent and sat_count is tied to 16'h0000. Datapath behaviour is identical either way.

Decomposition:
- Shared package sign_mag_pkg holds:
  - the function lzw_of(width) returning $clog2(width+1);
  - the constant SAT_CNT_W = 16;
  - a typedef for the S1 stage record {sign, sat, abs}.
- Sub-module sm_lzc: purely combinational leading-zero counter, parametrised by WIDTH and returning an LZW-bit count. It is instantiated once in S2 and reused later by the normaliser.

Test Plan (WIDTH=12):
- Send 12'h800, out_ready=1 → 2 cycles later: sign=1, abs=12'h7FF, sat=1, lzc=1. With macro defined, sat_count=1.
- Send 12'hFFF, 12'h001, 12'h000, 12'h7FF back-to-back → successive outputs:
  - abs 1, lzc 11, sign 1;
  - abs 1, lzc 11, sign 0;
  - abs 0, lzc 12, sign 0;
  - abs 12'h7FF, lzc 1.
  - All with no bubbles.
- Hold out_ready=0 and drive 4 valid inputs → exactly 2 accepted, then in_ready=0. Raise out_ready → outputs drain in order, then remaining inputs are accepted.
- Stream 1000 random samples with random out_ready (50%) → every output matches the reference model, in order, with a count equal to the accept count.
- Assert rst for 1 cycle with both stages full → next cycle out_valid=0, all outputs 0, sat_count=0. No stale sample emerges afterwards.
- Macro defined: force 70000 saturating samples → sat_count holds at 16'hFFFF.

Source files
------------

// File: rtl/sign_mag_pkg.sv
// sign_mag_pkg: shared definitions for the sign-magnitude conversion datapath.
//   lzw_of(width)  width of a leading-zero count able to hold 0..width
//   SAT_CNT_W      width of the saturation event counter
//   s1_flags_t     sign/sat part of the stage-1 record; the WIDTH-dependent
//                  magnitude field is appended by each user of the record
package sign_mag_pkg;

   localparam int unsigned SAT_CNT_W = 16;

   function automatic int unsigned lzw_of(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   typedef struct packed {
      logic sign;
      logic sat;
   } s1_flags_t;

endpackage

// File: rtl/sm_lzc.sv
// sm_lzc: combinational leading-zero counter.
// Ports:
//   i_abs  in  WIDTH  unsigned value
//   o_lzc  out LZW    zero bits above the most significant one; WIDTH when i_abs == 0
module sm_lzc
   import sign_mag_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   localparam int unsigned LZW = lzw_of(WIDTH)
) (
   input  logic [WIDTH-1:0] i_abs,
   output logic [LZW-1:0]   o_lzc
);

   // Scan upward so the highest set bit writes last and wins.
   always_comb begin
      o_lzc = LZW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i_abs[i]) begin
            o_lzc = LZW'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/sign_mag_pipe.sv
// sign_mag_pipe: two-stage pipelined two's-complement to sign-magnitude
// converter with valid/ready handshakes on both sides.
// Optional feature macro: SGNMAG_SAT_CNT_EN (saturation event counter).
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   in_data    two's-complement sample, in_valid/in_ready handshake
//   out_sign   sign of the sample
//   out_abs    unsigned magnitude (most-negative input saturates to max positive)
//   out_sat    magnitude was saturated
//   out_lzc    leading zeros of out_abs over WIDTH bits
//   out_valid/out_ready  output handshake
//   sat_count  saturated outputs transferred (0 when the counter is not built)
module sign_mag_pipe
   import sign_mag_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   localparam int unsigned LZW = lzw_of(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_sign,
   output logic [WIDTH-1:0]     out_abs,
   output logic                 out_sat,
   output logic [LZW-1:0]       out_lzc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SAT_CNT_W-1:0] sat_count
);

   typedef struct packed {
      s1_flags_t        flags;
      logic [WIDTH-1:0] abs;
   } s1_rec_t;

   localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MaxPos  = {1'b0, {(WIDTH-1){1'b1}}};

   logic             r_s1_valid;
   s1_rec_t          r_s1;
   logic             r_s2_valid;
   logic             r_out_sign;
   logic [WIDTH-1:0] r_out_abs;
   logic             r_out_sat;
   logic [LZW-1:0]   r_out_lzc;

   s1_rec_t          w_s1_next;
   logic             w_s1_load;
   logic             w_s2_load;
   logic             w_in_ready;
   logic             w_out_xfer;
   logic [LZW-1:0]   w_lzc;

   // Handshake / advance control
   assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
   assign w_in_ready = !rst && (!r_s1_valid || w_s2_load);
   assign w_s1_load  = in_valid && w_in_ready;
   assign w_out_xfer = r_s2_valid && out_ready;

   // Stage-1 conversion. The most-negative value has no positive counterpart
   // in WIDTH bits, so it is clamped to the largest positive magnitude.
   always_comb begin
      w_s1_next            = '0;
      w_s1_next.flags.sign = in_data[WIDTH-1];
      w_s1_next.flags.sat  = 1'b0;
      if (in_data == MostNeg) begin
         w_s1_next.abs       = MaxPos;
         w_s1_next.flags.sat = 1'b1;
      end else if (in_data[WIDTH-1]) begin
         w_s1_next.abs = ~in_data + WIDTH'(1);
      end else begin
         w_s1_next.abs = in_data;
      end
   end

   sm_lzc #(
      .WIDTH (WIDTH)
   ) u_lzc (
      .i_abs (r_s1.abs),
      .o_lzc (w_lzc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
         r_s2_valid <= 1'b0;
         r_out_sign <= 1'b0;
         r_out_abs  <= '0;
         r_out_sat  <= 1'b0;
         r_out_lzc  <= '0;
      end else begin
         // S1 may be refilled in the same cycle its old contents move to S2.
         if (w_s1_load) begin
            r_s1       <= w_s1_next;
            r_s1_valid <= 1'b1;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end

         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_out_sign <= r_s1.flags.sign;
            r_out_abs  <= r_s1.abs;
            r_out_sat  <= r_s1.flags.sat;
            r_out_lzc  <= w_lzc;
         end else if (w_out_xfer) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

`ifdef SGNMAG_SAT_CNT_EN
   logic [SAT_CNT_W-1:0] r_sat_count;

   // Sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_count <= '0;
      end else if (w_out_xfer && r_out_sat && (r_sat_count != '1)) begin
         r_sat_count <= r_sat_count + SAT_CNT_W'(1);
      end
   end

   assign sat_count = r_sat_count;
`else
   assign sat_count = '0;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = r_s2_valid;
   assign out_sign  = r_out_sign;
   assign out_abs   = r_out_abs;
   assign out_sat   = r_out_sat;
   assign out_lzc   = r_out_lzc;

endmodule

// File: tb/tb_sign_mag_pipe.sv
// tb_sign_mag_pipe: self-checking bench for sign_mag_pipe (WIDTH = 12).
// Expected outputs come from an integer-arithmetic reference model and a FIFO
// of accepted samples.
module tb_sign_mag_pipe;

   localparam int W   = 12;
   localparam int LZW = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           out_sign;
   logic [W-1:0]   out_abs;
   logic           out_sat;
   logic [LZW-1:0] out_lzc;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [15:0]    sat_count;

   sign_mag_pipe #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sign  (out_sign),
      .out_abs   (out_abs),
      .out_sat   (out_sat),
      .out_lzc   (out_lzc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sign;
      int           abs;
      logic         sat;
      int           lzc;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   exp_sat = 0;
   int   n_acc   = 0;
   int   n_out   = 0;
   bit   chk_lat = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: signed value, absolute value clamped to the positive range,
   // lzc = width minus the bit length of the magnitude.
   function automatic exp_t model(input logic [W-1:0] d, input int c);
      exp_t e;
      int v;
      int m;
      int n;
      v = int'($signed(d));
      e.sign = (v < 0);
      m = (v < 0) ? -v : v;
      e.sat = 1'b0;
      if (m > (1 << (W - 1)) - 1) begin
         m = (1 << (W - 1)) - 1;
         e.sat = 1'b1;
      end
      e.abs = m;
      n = 0;
      while (m > 0) begin
         m = m >> 1;
         n++;
      end
      e.lzc = W - n;
      e.cyc = c;
      return e;
   endfunction

   // One clock cycle: drive, observe both handshakes, advance.
   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 32'(out_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check_eq("sign", 32'(out_sign), 32'(e.sign));
            check_eq("abs", 32'(out_abs), 32'(e.abs));
            check_eq("sat", 32'(out_sat), 32'(e.sat));
            check_eq("lzc", 32'(out_lzc), 32'(e.lzc));
            if (chk_lat) check_eq("latency", 32'(cyc - e.cyc), 32'(2));
`ifdef SGNMAG_SAT_CNT_EN
            if (e.sat && exp_sat != 65535) exp_sat++;
`endif
         end
      end
      if (acc) begin
         n_acc++;
         exp_q.push_back(model(d, cyc));
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic drain();
      logic acc;
      int   budget;
      budget = 20;
      while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
         step(1'b0, '0, 1'b1, acc);
         budget--;
      end
      check_eq("drain_empty", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'(0));
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'(0));
      check_eq("rst_out_sign", 32'(out_sign), 32'(0));
      check_eq("rst_out_abs", 32'(out_abs), 32'(0));
      check_eq("rst_out_sat", 32'(out_sat), 32'(0));
      check_eq("rst_out_lzc", 32'(out_lzc), 32'(0));
      check_eq("rst_sat_count", 32'(sat_count), 32'(0));
      exp_q.delete();
      exp_sat = 0;
   endtask

   logic [W-1:0] b2b_in[4];
   logic [W-1:0] stall_in[4];

   initial begin
      logic acc;
      int   idx;
      int   budget;
      logic [W-1:0] d;

      b2b_in   = '{12'hFFF, 12'h001, 12'h000, 12'h7FF};
      stall_in = '{12'h123, 12'h8FF, 12'hC00, 12'h040};

      do_reset(3);

      // Most-negative sample saturates
      chk_lat = 1'b1;
      step(1'b1, 12'h800, 1'b1, acc);
      check_eq("mostneg_accept", 32'(acc), 32'(1));
      drain();
      step(1'b0, '0, 1'b1, acc);
      check_eq("sat_count_one", 32'(sat_count), 32'(exp_sat));

      // Back-to-back, no bubbles
      for (int i = 0; i < 4; i++) begin
         step(1'b1, b2b_in[i], 1'b1, acc);
         check_eq("b2b_accept", 32'(acc), 32'(1));
      end
      drain();
      chk_lat = 1'b0;

      // Stall: only two samples fit while out_ready is low
      idx = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, stall_in[idx], 1'b0, acc);
         if (acc) idx++;
      end
      check_eq("stall_accepted", 32'(idx), 32'(2));
      #1;
      check_eq("stall_in_ready", 32'(in_ready), 32'(0));
      budget = 20;
      while (idx < 4 && budget > 0) begin
         step(1'b1, stall_in[idx], 1'b1, acc);
         if (acc) idx++;
         budget--;
      end
      check_eq("stall_resume", 32'(idx), 32'(4));
      drain();

      // Random stream with random backpressure
      n_acc  = 0;
      n_out  = 0;
      idx    = 0;
      budget = 20000;
      d      = W'($urandom);
      while (idx < 1000 && budget > 0) begin
         step(($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            idx++;
            case ($urandom_range(0, 7))
               0: d = 12'h800;
               1: d = 12'h000;
               2: d = 12'hFFF;
               3: d = 12'h7FF;
               default: d = W'($urandom);
            endcase
         end
         budget--;
      end
      check_eq("rand_accepted", 32'(idx), 32'(1000));
      drain();
      check_eq("rand_out_count", 32'(n_out), 32'(n_acc));
      step(1'b0, '0, 1'b1, acc);
      check_eq("rand_sat_count", 32'(sat_count), 32'(exp_sat));

      // Reset with both stages full discards everything
      step(1'b1, 12'h801, 1'b0, acc);
      step(1'b1, 12'h802, 1'b0, acc);
      #1;
      check_eq("full_out_valid", 32'(out_valid), 32'(1));
      check_eq("full_in_ready", 32'(in_ready), 32'(0));
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, 1'b1, acc);
      end
      check_eq("post_rst_out_valid", 32'(out_valid), 32'(0));

`ifdef SGNMAG_SAT_CNT_EN
      // Counter saturation
      for (int i = 0; i < 70000; i++) begin
         step(1'b1, 12'h800, 1'b1, acc);
      end
      drain();
      step(1'b0, '0, 1'b1, acc);
      check_eq("sat_count_max", 32'(sat_count), 32'(exp_sat));
      check_eq("sat_count_ffff", 32'(sat_count), 32'h0000FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
